// File: rtl/dcm_lock_sequencer.sv
// Sequences the DCM through reset, lock acquisition and settling; holds the system reset until the synthesized clocks are stable.
// Optional retry limit: define DCM_SEQ_RETRY_LIMIT_EN to latch FAIL after MAX_RETRIES failed attempts.
//   state     | meaning
//   RESET_DCM | DCM RST pulsed for RST_CYCLES
//   WAIT_LOCK | waiting for synchronized LOCKED, bounded by LOCK_TIMEOUT
//   SETTLE    | lock must hold fault-free for SETTLE_CYCLES
//   RUN       | clocks good, system reset released
//   FAIL      | retry limit reached, parked until rst_i
module dcm_lock_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 17,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dcm_locked_i,
  input  logic [7:0] dcm_status_i,
  output logic       dcm_rst_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic [7:0] retry_count_o,
  output logic       fail_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

`ifdef DCM_SEQ_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIM = 8'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [2:0]       sync_meta_q, sync_meta_d;
  logic [2:0]       sync_q, sync_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             locked_q, locked_d;
  logic             locked_s, clkin_stop_s, fx_stop_s, fault, bump;
  logic             unused_status_bits;

  // Only CLKIN-stopped and CLKFX-stopped are meaningful status bits.
  assign unused_status_bits = ^{dcm_status_i[7:3], dcm_status_i[0]};

  assign sync_meta_d = {dcm_status_i[2], dcm_status_i[1], dcm_locked_i};
  assign sync_d      = sync_meta_q;
  assign {fx_stop_s, clkin_stop_s, locked_s} = sync_q;
  assign fault = !locked_s || clkin_stop_s || fx_stop_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    bump    = 1'b0;
    case (state_q)
      RESET_DCM: begin
        if (cnt_q == RST_TC) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_TC) begin
          bump = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (fault) begin
          bump = 1'b1;
        end else if (cnt_q == SETTLE_TC) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (fault) bump = 1'b1;
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RESET_DCM;
        cnt_d   = '0;
      end
    endcase

    if (bump) begin
      cnt_d   = '0;
      retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
      state_d = (LIMIT_EN && retry_d == RETRY_LIM) ? FAIL : RESET_DCM;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    dcm_rst_d = (state_d == RESET_DCM) || (state_d == FAIL);
    sys_rst_d = (state_d != RUN);
    locked_d  = (state_d == RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RESET_DCM;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync_meta_q <= '0;
      sync_q      <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      dcm_rst_q   <= dcm_rst_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
    end
  end

`ifdef DCM_SEQ_RETRY_LIMIT_EN
  logic fail_q, fail_d;

  assign fail_d = (state_d == FAIL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fail_q <= 1'b0;
    else       fail_q <= fail_d;
  end

  assign fail_o = fail_q;
`else
  assign fail_o = 1'b0;
`endif

  assign dcm_rst_o     = dcm_rst_q;
  assign sys_rst_o     = sys_rst_q;
  assign locked_o      = locked_q;
  assign retry_count_o = retry_q;
  assign state_o       = state_q;

endmodule
